collision_scheduler: RTL
========================

# collision_scheduler

Once per video frame, checks every active projectile slot against every player with a single shared two-stage distance-check pipeline, one projectile/player pair per cycle. Produces a per-projectile hit mask and a per-player hit count for game logic. Sits between the object-state registers (projectile and player positions) and the game-state update logic. Results are stable for a whole frame.

## Interface

Parameters:
- N_PROJ, 8, number of projectile slots
- N_PLAYER, 2, number of players
- CW, 10, coordinate width (screen 640x480)

Ports (reset reset, synchronous, active-high; clock clk):
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- frame_start  in  1  single-cycle pulse at start of vertical blank
- proj_x  in  N_PROJ*CW  projectile X, slot i at [i*CW +: CW]
- proj_y  in  N_PROJ*CW  projectile Y, same packing
- proj_active  in  N_PROJ  slot valid bits
- player_x  in  N_PLAYER*CW  player X, same packing
- player_y  in  N_PLAYER*CW  player Y
- radius  in  CW  hit radius, unsigned
- busy  out  1  scan in progress
- done  out  1  single-cycle pulse when results update
- hit_mask  out  N_PROJ  bit i set: slot i hit at least one player
- player_hits  out  N_PLAYER*4  per-player count of projectiles hitting it, player j at [j*4 +: 4]
- overrun  out  1  sticky: frame_start arrived while busy

## Operation

- FSM states: IDLE, LATCH, SCAN, DRAIN, DONE.
- IDLE, frame_start=1 -> LATCH. Other inputs are ignored in IDLE.
- LATCH, 1 cycle: snapshot all position, active and radius inputs into internal registers. Clear the working accumulators. Go to SCAN.
- SCAN, N_PROJ*N_PLAYER cycles: issue one pair per cycle.
  - Outer index is projectile i, inner index is player j: (0,0),(0,1),(1,0)...
  - The issue-valid bit equals the latched proj_active[i]. Inactive pairs still consume a cycle, so the cycle count is fixed.
  - After the last pair, go to DRAIN.
- DRAIN, 2 cycles: flush the pipeline. Go to DONE.
- DONE, 1 cycle:
  - done=1.
  - Working mask and counts are copied to hit_mask/player_hits, registered, so they are visible in this same cycle.
  - Go to IDLE.
- busy=1 in LATCH, SCAN, DRAIN and DONE.
- frame_start while busy is ignored and sets overrun. overrun clears only on reset.
- Distance arithmetic:
  - DX = X - PX and DY = Y - PY, as (CW+1)-bit signed values.
  - Squares are 2*CW+2 bits unsigned; the sum is 2*CW+3 bits.
  - radius² is 2*CW bits.
  - Hit when DX²+DY² <= radius², inclusive.
  - No truncation anywhere in this path.
- Accumulation on a valid hit for pair (i,j): set mask bit i and increment count j.
  - The count width accommodates N_PROJ=8 without saturation.
  - The count saturates at 15 if N_PROJ is raised.

## Timing

- Reset, synchronous: state IDLE; busy, done, overrun = 0; hit_mask = 0; player_hits = 0; pipeline valids = 0.
- Reset mid-scan: returns to IDLE the next cycle. Outputs clear, done does not pulse, and partial results are discarded.
- frame_start sampled high at cycle k in IDLE gives:
  - LATCH at k+1
  - SCAN at k+2 .. k+1+N_PROJ*N_PLAYER
  - DRAIN for 2 cycles
  - done at k+N_PROJ*N_PLAYER+4, which is k+20 for the defaults
- Total occupancy is N_PROJ*N_PLAYER+4 cycles, far below the vertical-blank length.
- hit_check latency is exactly 2 cycles from pair issue to accumulator update. The last pair lands before DONE.
- Outputs hold between DONE cycles.

## Structure

- Shared game package (collide_pkg): CW, the state enum type, the HITCNT_W=4 constant, and a function computing radius-squared width.
- Sub-module hit_check: 2-stage pipeline.
  - Stage 1 registers DX², DY², radius² and valid.
  - Stage 2 registers hit = valid && (sum <= r²), together with the pair's indices.
- Top level holds the FSM, index counters, snapshot registers and accumulators. Target size is about 200 lines.

## Test plan

1. Reset asserted -> all outputs 0, busy=0. frame_start is ignored while reset is held.
2. Slot 0 active at (100,100), player 0 at (103,104), radius 5, frame_start at k -> done at k+20, hit_mask=0x01, player_hits[0]=1, player_hits[1]=0.
3. Inclusive boundary:
   - Player at (103,105), radius 5 (distance² 34 > 25) -> hit_mask=0.
   - Coincident positions with radius 0 -> hit.
4. All 8 slots coincident with player 1, slot 3 inactive -> hit_mask=0xF7, player_hits[1]=7, player_hits[0]=0.
5. Width check: slot at (0,0), player at (639,479), radius 1023 -> hit (637762 <= 1046529). Same positions with radius 798 -> miss (636804 < 637762).
6. Control events:
   - frame_start at k+5 during a scan -> overrun=1, single done at k+20.
   - reset at k+10 -> busy=0 at k+11, no done pulse, outputs 0.

Source files
------------

// File: rtl/collide_pkg.sv
// Shared collision types and constants: coordinate width, FSM state
// encoding, hit-count width and the radius-squared width helper.
package collide_pkg;

   localparam int CW       = 10;
   localparam int HITCNT_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LATCH = 3'd1,
      ST_SCAN  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // radius is unsigned cw bits, so its square never needs more than 2*cw.
   function automatic int r2_width(input int cw);
      return 2 * cw;
   endfunction

endpackage

// File: rtl/hit_check.sv
// Two-stage projectile/player distance check. Stage 1 squares the deltas
// and the radius; stage 2 compares the full-width sum against radius^2.
// Pair indices travel alongside so the accumulator knows where to credit.
module hit_check #(
   parameter int CW  = 10,
   parameter int PIW = 3,
   parameter int PLW = 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   input  logic [CW-1:0]  in_x,
   input  logic [CW-1:0]  in_y,
   input  logic [CW-1:0]  in_px,
   input  logic [CW-1:0]  in_py,
   input  logic [CW-1:0]  in_radius,
   input  logic [PIW-1:0] in_pi,
   input  logic [PLW-1:0] in_pj,
   output logic           hit,
   output logic [PIW-1:0] hit_pi,
   output logic [PLW-1:0] hit_pj
);
   import collide_pkg::*;

   localparam int R2W  = r2_width(CW);
   localparam int SQW  = 2 * CW + 2;
   localparam int SUMW = 2 * CW + 3;

   logic signed [CW:0]    dx, dy;
   logic signed [SQW-1:0] dxe, dye, dx2_c, dy2_c;
   logic [R2W-1:0]        rext, r2_c;

   logic                  s1_vld;
   logic [SQW-1:0]        s1_dx2, s1_dy2;
   logic [R2W-1:0]        s1_r2;
   logic [PIW-1:0]        s1_pi;
   logic [PLW-1:0]        s1_pj;
   logic [SUMW-1:0]       sum;

   // Signed deltas are extended before squaring so no bit of the product is lost.
   always_comb begin
      dx    = $signed({1'b0, in_x}) - $signed({1'b0, in_px});
      dy    = $signed({1'b0, in_y}) - $signed({1'b0, in_py});
      dxe   = {{(SQW-CW-1){dx[CW]}}, dx};
      dye   = {{(SQW-CW-1){dy[CW]}}, dy};
      dx2_c = dxe * dxe;
      dy2_c = dye * dye;
      rext  = {{(R2W-CW){1'b0}}, in_radius};
      r2_c  = rext * rext;
      sum   = {1'b0, s1_dx2} + {1'b0, s1_dy2};
   end

   // Stage 1: squares, radius^2, valid and indices.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_vld <= 1'b0;
      end else begin
         s1_vld <= in_valid;
      end
      s1_dx2 <= $unsigned(dx2_c);
      s1_dy2 <= $unsigned(dy2_c);
      s1_r2  <= r2_c;
      s1_pi  <= in_pi;
      s1_pj  <= in_pj;
   end

   // Stage 2: inclusive compare, qualified by the pair's valid bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         hit <= 1'b0;
      end else begin
         hit <= s1_vld && (sum <= {{(SUMW-R2W){1'b0}}, s1_r2});
      end
      hit_pi <= s1_pi;
      hit_pj <= s1_pj;
   end

endmodule

// File: rtl/collision_scheduler.sv
// Per-frame projectile vs player collision scan. Snapshots object state on
// frame_start, walks every (projectile, player) pair through one shared
// hit_check pipeline, and publishes a hit mask and per-player hit counts.
module collision_scheduler #(
   parameter int N_PROJ   = 8,
   parameter int N_PLAYER = 2,
   parameter int CW       = collide_pkg::CW
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   frame_start,
   input  logic [N_PROJ*CW-1:0]   proj_x,
   input  logic [N_PROJ*CW-1:0]   proj_y,
   input  logic [N_PROJ-1:0]      proj_active,
   input  logic [N_PLAYER*CW-1:0] player_x,
   input  logic [N_PLAYER*CW-1:0] player_y,
   input  logic [CW-1:0]          radius,
   output logic                   busy,
   output logic                   done,
   output logic [N_PROJ-1:0]      hit_mask,
   output logic [N_PLAYER*4-1:0]  player_hits,
   output logic                   overrun
);
   import collide_pkg::*;

   localparam int PIW = (N_PROJ   > 1) ? $clog2(N_PROJ)   : 1;
   localparam int PLW = (N_PLAYER > 1) ? $clog2(N_PLAYER) : 1;

   state_t                              state;
   logic [PIW-1:0]                      pi;
   logic [PLW-1:0]                      pj;
   logic                                dcnt;

   logic [N_PROJ*CW-1:0]                px_q, py_q;
   logic [N_PROJ-1:0]                   act_q;
   logic [N_PLAYER*CW-1:0]              qx_q, qy_q;
   logic [CW-1:0]                       r_q;

   logic                                iss_valid;
   logic                                hc_hit;
   logic [PIW-1:0]                      hc_pi;
   logic [PLW-1:0]                      hc_pj;

   logic [N_PROJ-1:0]                   acc_mask, mask_nxt;
   logic [N_PLAYER-1:0][HITCNT_W-1:0]   acc_cnt, cnt_nxt, hits_q;

   assign busy        = (state != ST_IDLE);
   assign iss_valid   = (state == ST_SCAN) && act_q[pi];
   assign player_hits = hits_q;

   hit_check #(.CW(CW), .PIW(PIW), .PLW(PLW)) u_hit_check (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (iss_valid),
      .in_x      (px_q[pi*CW +: CW]),
      .in_y      (py_q[pi*CW +: CW]),
      .in_px     (qx_q[pj*CW +: CW]),
      .in_py     (qy_q[pj*CW +: CW]),
      .in_radius (r_q),
      .in_pi     (pi),
      .in_pj     (pj),
      .hit       (hc_hit),
      .hit_pi    (hc_pi),
      .hit_pj    (hc_pj)
   );

   // Fold the pipeline's current result into the working mask and counts.
   always_comb begin
      mask_nxt = acc_mask;
      cnt_nxt  = acc_cnt;
      if (hc_hit) begin
         mask_nxt[hc_pi] = 1'b1;
         if (cnt_nxt[hc_pj] != {HITCNT_W{1'b1}})
            cnt_nxt[hc_pj] = cnt_nxt[hc_pj] + HITCNT_W'(1);
      end
   end

   // Working accumulators: cleared at snapshot time, otherwise track next value.
   always_ff @(posedge clk) begin
      if (reset || state == ST_LATCH) begin
         acc_mask <= '0;
         acc_cnt  <= '0;
      end else begin
         acc_mask <= mask_nxt;
         acc_cnt  <= cnt_nxt;
      end
   end

   // Snapshot of object state; only the LATCH cycle loads it.
   always_ff @(posedge clk) begin
      if (state == ST_LATCH) begin
         px_q  <= proj_x;
         py_q  <= proj_y;
         act_q <= proj_active;
         qx_q  <= player_x;
         qy_q  <= player_y;
         r_q   <= radius;
      end
   end

   // Scan FSM, pair counters, result publication and overrun flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         pi       <= '0;
         pj       <= '0;
         dcnt     <= 1'b0;
         done     <= 1'b0;
         overrun  <= 1'b0;
         hit_mask <= '0;
         hits_q   <= '0;
      end else begin
         done <= 1'b0;
         if (frame_start && state != ST_IDLE)
            overrun <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (frame_start)
                  state <= ST_LATCH;
            end
            ST_LATCH: begin
               pi    <= '0;
               pj    <= '0;
               state <= ST_SCAN;
            end
            ST_SCAN: begin
               if (pj == PLW'(N_PLAYER - 1)) begin
                  pj <= '0;
                  if (pi == PIW'(N_PROJ - 1)) begin
                     dcnt  <= 1'b0;
                     state <= ST_DRAIN;
                  end else begin
                     pi <= pi + PIW'(1);
                  end
               end else begin
                  pj <= pj + PLW'(1);
               end
            end
            ST_DRAIN: begin
               // The final pair's result is in hit_check's output now, so
               // publish the next-value to make it visible alongside done.
               if (dcnt) begin
                  state    <= ST_DONE;
                  done     <= 1'b1;
                  hit_mask <= mask_nxt;
                  hits_q   <= cnt_nxt;
               end else begin
                  dcnt <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
